// File: rtl/clk_div_seq_pkg.sv
// rtl/clk_div_seq_pkg.sv - shared types and constants for the clock divider sequencer
//
// Purpose : sequencer state encoding and the minimum legal half-period.
// Ports   : none (package).

package clk_div_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } seq_state_t;

    // Smallest half-period; a requested 0 is promoted to this value.
    localparam int N_MIN = 1;

endpackage

// File: rtl/clk_div_sequencer_if.sv
// rtl/clk_div_sequencer_if.sv - control/status bundle between host and clock divider sequencer
//
// Purpose : groups start/stop, the half-period config handshake and the divided
//           clock outputs. The period_count signal exists only when
//           CLK_DIV_SEQ_PERIOD_CNT_EN is defined.
// Ports   : master = host side (drives start, stop, cfg_valid, cfg_n)
//           slave  = sequencer side (drives cfg_ready, clk_out, rise_tick,
//                    fall_tick, running, period_count)

interface clk_div_sequencer_if #(
    parameter int WIDTH = 8
`ifdef CLK_DIV_SEQ_PERIOD_CNT_EN
  , parameter int CNT_W = 16
`endif
);

    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_n;
    logic             cfg_ready;
    logic             clk_out;
    logic             rise_tick;
    logic             fall_tick;
    logic             running;
`ifdef CLK_DIV_SEQ_PERIOD_CNT_EN
    logic [CNT_W-1:0] period_count;

    modport master (
        output start, stop, cfg_valid, cfg_n,
        input  cfg_ready, clk_out, rise_tick, fall_tick, running, period_count
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_n,
        output cfg_ready, clk_out, rise_tick, fall_tick, running, period_count
    );
`else
    modport master (
        output start, stop, cfg_valid, cfg_n,
        input  cfg_ready, clk_out, rise_tick, fall_tick, running
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_n,
        output cfg_ready, clk_out, rise_tick, fall_tick, running
    );
`endif

endinterface

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - half-period counter and divided clock toggle register
//
// Purpose : counts 0..N_active-1 and toggles clk_out at the terminal count.
//           Holds cnt and clk_out at 0 while en is low.
// Ports   : clk_in, reset     - clock, asynchronous active-high reset
//           en                - divide when high, hold cleared when low
//           load, n_load      - replace N_active at the next edge
//           clk_out           - registered divided clock
//           toggle_hi2lo      - this edge takes clk_out from 1 to 0
//           toggle_lo2hi      - this edge takes clk_out from 0 to 1

module clk_div_core #(
    parameter int WIDTH   = 8,
    parameter int N_RESET = 1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] n_load,
    output logic             clk_out,
    output logic             toggle_hi2lo,
    output logic             toggle_lo2hi
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] n_active;
    logic             at_end;

    // N_active is never 0, so the subtraction cannot wrap.
    assign at_end       = (cnt == (n_active - WIDTH'(1)));
    assign toggle_hi2lo = en && at_end && clk_out;
    assign toggle_lo2hi = en && at_end && !clk_out;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            clk_out  <= 1'b0;
            n_active <= WIDTH'(N_RESET);
        end else begin
            if (load) begin
                n_active <= n_load;
            end
            if (!en) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end else if (at_end) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_sequencer.sv
// rtl/clk_div_sequencer.sv - run-time programmable even clock divider controller
//
// Purpose : start/stop sequencing, half-period reprogramming and tick
//           generation around clk_div_core. Divisor changes and stops only
//           land on the high-to-low toggle, so no runt pulses are produced.
//           Optional feature macro: CLK_DIV_SEQ_PERIOD_CNT_EN adds the
//           completed-period counter period_count.
// Ports   : clk_in  - sole clock
//           reset   - asynchronous active-high reset
//           bus     - clk_div_sequencer_if.slave (start, stop, cfg_valid,
//                     cfg_n in; cfg_ready, clk_out, rise_tick, fall_tick,
//                     running, [period_count] out)

module clk_div_sequencer
    import clk_div_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int N_RESET = 1,
    parameter int CNT_W   = 16
) (
    input  logic                  clk_in,
    input  logic                  reset,
    clk_div_sequencer_if.slave    bus
);

    if (N_RESET < N_MIN || N_RESET >= (1 << WIDTH) || CNT_W < 1) begin : g_bad_param
        $error("clk_div_sequencer: illegal N_RESET/WIDTH/CNT_W combination");
    end

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic             en;
    logic             load;
    logic             xfer;
    logic             cfg_ready_q;
    logic [WIDTH-1:0] n_pend;
    logic             toggle_hi2lo;
    logic             toggle_lo2hi;
    logic             rise_tick_q;
    logic             fall_tick_q;
    logic             core_clk_out;

    clk_div_core #(
        .WIDTH   (WIDTH),
        .N_RESET (N_RESET)
    ) u_core (
        .clk_in       (clk_in),
        .reset        (reset),
        .en           (en),
        .load         (load),
        .n_load       (n_pend),
        .clk_out      (core_clk_out),
        .toggle_hi2lo (toggle_hi2lo),
        .toggle_lo2hi (toggle_lo2hi)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        en      = (state_q != IDLE);
        xfer    = bus.cfg_valid && cfg_ready_q;
        // A staged value lands immediately when idle, otherwise only on the
        // falling toggle so the next low phase is the first to use it.
        load    = !cfg_ready_q && ((state_q == IDLE) || toggle_hi2lo);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = STOP_PEND;
                end
            end
            STOP_PEND: begin
                // The final fall wins over a same-edge start, keeping the
                // next low phase a full N cycles long.
                if (toggle_hi2lo) begin
                    state_d = IDLE;
                end else if (bus.start && !bus.stop) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cfg_ready_q <= 1'b1;
            n_pend      <= WIDTH'(N_MIN);
        end else if (xfer) begin
            cfg_ready_q <= 1'b0;
            n_pend      <= (bus.cfg_n == '0) ? WIDTH'(N_MIN) : bus.cfg_n;
        end else if (load) begin
            cfg_ready_q <= 1'b1;
        end
    end

    // Ticks are registered from the same toggle decode as clk_out so they
    // line up with it cycle for cycle.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rise_tick_q <= 1'b0;
            fall_tick_q <= 1'b0;
        end else begin
            rise_tick_q <= toggle_lo2hi;
            fall_tick_q <= toggle_hi2lo;
        end
    end

`ifdef CLK_DIV_SEQ_PERIOD_CNT_EN
    logic [CNT_W-1:0] period_cnt_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            period_cnt_q <= '0;
        end else if (toggle_hi2lo) begin
            period_cnt_q <= period_cnt_q + CNT_W'(1);
        end
    end

    assign bus.period_count = period_cnt_q;
`endif

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.clk_out   = core_clk_out;
    assign bus.rise_tick = rise_tick_q;
    assign bus.fall_tick = fall_tick_q;
    assign bus.running   = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_sequencer.sv
// tb/tb_clk_div_sequencer.sv - scoreboard testbench for clk_div_sequencer

module tb_clk_div_sequencer;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   cyc    = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   model_n  = 1;
    int   exp_per  = 0;

    typedef struct {
        int cyc;
        bit rise;
    } ev_t;

    ev_t exp_q[$];

`ifdef CLK_DIV_SEQ_PERIOD_CNT_EN
    clk_div_sequencer_if #(.WIDTH(8), .CNT_W(4)) bus ();
`else
    clk_div_sequencer_if #(.WIDTH(8)) bus ();
`endif

    clk_div_sequencer #(
        .WIDTH   (8),
        .N_RESET (1),
        .CNT_W   (4)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Monitor: every tick pulse must match the oldest expected edge.
    always @(negedge clk_in) begin
        if (!reset && (bus.rise_tick || bus.fall_tick)) begin
            if (exp_q.size() == 0) begin
                chk("tick_unexpected", 1, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk("tick_kind", bus.rise_tick, e.rise);
                chk("tick_clk_out", bus.clk_out, e.rise);
            end
        end
    end

    task automatic check_period_count();
`ifdef CLK_DIV_SEQ_PERIOD_CNT_EN
        chk("period_count", bus.period_count, exp_per % 16);
`endif
    endtask

    task automatic idle_cfg(input int val);
        bus.cfg_valid = 1'b1;
        bus.cfg_n     = 8'(val);
        step();
        bus.cfg_valid = 1'b0;
        chk("idle_cfg_ready_low", bus.cfg_ready, 0);
        step();
        chk("idle_cfg_ready_back", bus.cfg_ready, 1);
        model_n = (val == 0) ? 1 : val;
    endtask

    // One start..halt episode. Offsets are edges after the start edge k.
    task automatic run_scn(input bit do_cfg, input int cfg_off, input int cfg_val,
                           input int stop_off, input bit do_res, input int res_off,
                           input int stop2_off);
        int k, cur, n, t, s, r, s2, act, f_cfg, f_stop, fall, last, e;
        bit used, applied;
        k = cyc + 1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("running_after_start", bus.running, 1);
        t = k + cfg_off;
        s = k + stop_off;
        r = k + res_off;
        s2 = k + stop2_off;
        act = s;
        cur = k;
        n = model_n;
        f_cfg = -1;
        f_stop = -1;
        used = 1'b0;
        applied = !do_cfg;
        // Reference: each period is n low cycles then n high cycles; changes
        // and halts apply at the first fall strictly after they are accepted.
        while (f_stop < 0) begin
            fall = cur + 2 * n;
            exp_q.push_back('{cur + n, 1'b1});
            exp_q.push_back('{fall, 1'b0});
            exp_per++;
            if (!applied && fall > t) begin
                applied = 1'b1;
                f_cfg = fall;
                n = (cfg_val == 0) ? 1 : cfg_val;
            end
            if (fall > act) begin
                if (do_res && !used && r < fall) begin
                    used = 1'b1;
                    act = s2;
                    if (fall > s2) f_stop = fall;
                end else begin
                    f_stop = fall;
                end
            end
            cur = fall;
        end
        model_n = n;
        last = f_stop + 3;
        while (cyc < last) begin
            e = cyc + 1;
            bus.start     = do_res && (e == r);
            bus.stop      = (e == s) || (do_res && e == s2);
            bus.cfg_valid = do_cfg && (e == t);
            bus.cfg_n     = 8'(cfg_val);
            step();
            bus.start     = 1'b0;
            bus.stop      = 1'b0;
            bus.cfg_valid = 1'b0;
            if (do_cfg && cyc == t)         chk("run_cfg_ready_low", bus.cfg_ready, 0);
            if (do_cfg && cyc == f_cfg - 1) chk("run_cfg_ready_held", bus.cfg_ready, 0);
            if (do_cfg && cyc == f_cfg)     chk("run_cfg_ready_back", bus.cfg_ready, 1);
            if (cyc == f_stop - 1) begin
                chk("pre_stop_running", bus.running, 1);
                chk("pre_stop_clk_out", bus.clk_out, 1);
            end
            if (cyc == f_stop) begin
                chk("stop_running", bus.running, 0);
                chk("stop_clk_out", bus.clk_out, 0);
            end
            if (cyc == f_stop + 2) begin
                chk("idle_clk_out", bus.clk_out, 0);
                chk("idle_running", bus.running, 0);
            end
        end
        chk("queue_drained", exp_q.size(), 0);
        check_period_count();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int k, n0, so, co, cv;
        bit dc;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_n     = '0;
        step();
        step();
        chk("rst_clk_out", bus.clk_out, 0);
        chk("rst_rise_tick", bus.rise_tick, 0);
        chk("rst_fall_tick", bus.fall_tick, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        reset = 1'b0;
        step();
        check_period_count();

        // N_RESET=1: period 2.
        run_scn(0, 0, 0, 7, 0, 0, 0);
        // IDLE program N=3.
        idle_cfg(3);
        run_scn(0, 0, 0, 13, 0, 0, 0);
        // N=4 running, new N=2 offered during the high phase.
        idle_cfg(4);
        run_scn(1, 6, 2, 20, 0, 0, 0);
        // N=5, stop in the second low cycle.
        idle_cfg(5);
        run_scn(0, 0, 0, 2, 0, 0, 0);
        // Stop then resume during STOP_PEND, later stop for real.
        idle_cfg(4);
        run_scn(0, 0, 0, 2, 1, 5, 12);

        // Reset in the third high cycle at N=4.
        idle_cfg(4);
        k = cyc + 1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        exp_q.push_back('{k + 4, 1'b1});
        while (cyc < k + 6) step();
        chk("pre_reset_clk_out", bus.clk_out, 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_clk_out", bus.clk_out, 0);
        chk("mid_reset_running", bus.running, 0);
        chk("mid_reset_cfg_ready", bus.cfg_ready, 1);
        chk("mid_reset_queue", exp_q.size(), 0);
        step();
        reset = 1'b0;
        model_n = 1;
        exp_per = 0;
        check_period_count();
        run_scn(0, 0, 0, 5, 0, 0, 0);

        // cfg_n=0 behaves as N=1.
        idle_cfg(0);
        run_scn(0, 0, 0, 9, 0, 0, 0);

        // Randomized episodes.
        for (int i = 0; i < 10; i++) begin
            n0 = $urandom_range(1, 6);
            idle_cfg(n0);
            so = $urandom_range(1, 6 * n0);
            dc = 1'($urandom_range(0, 1));
            co = $urandom_range(1, so);
            cv = $urandom_range(0, 6);
            run_scn(dc, co, cv, so, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
